// File: rtl/qam_symbol_source.sv
// rtl/qam_symbol_source.sv - packed-pattern symbol source for the QAM modulator
// Slices a loaded pattern LSB-first into symbols held for period+1 cycles each.
module qam_symbol_source #(
  parameter int PATTERN_W    = 30,
  parameter int BITS_PER_SYM = 2,
  parameter int SYM_PERIOD_W = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [PATTERN_W-1:0]      load_data,
  input  logic [SYM_PERIOD_W-1:0]   period,
  input  logic                      loop_en,
  input  logic                      abort,
  output logic [BITS_PER_SYM/2-1:0] sym_i,
  output logic [BITS_PER_SYM/2-1:0] sym_q,
  output logic                      elojel_sin,
  output logic                      elojel_cos,
  output logic                      sym_strobe,
  output logic                      wrap,
  output logic                      done,
  output logic                      busy
);

  localparam int HALF   = BITS_PER_SYM / 2;
  localparam int NSYM   = PATTERN_W / BITS_PER_SYM;
  localparam int LEFT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [LEFT_W-1:0] LAST_IDX = LEFT_W'(NSYM - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state_q;
  logic [PATTERN_W-1:0]    shift_q;
  logic [PATTERN_W-1:0]    copy_q;
  logic [SYM_PERIOD_W-1:0] period_q;
  logic [SYM_PERIOD_W-1:0] cnt_q;
  logic [SYM_PERIOD_W-1:0] cnt_d;
  logic [LEFT_W-1:0]       left_q;
  logic [BITS_PER_SYM-1:0] symbol_q;
  logic                    strobe_q;
  logic                    wrap_q;
  logic                    done_q;
  logic                    boundary;

  assign boundary = (cnt_q == period_q);
  assign cnt_d    = boundary ? '0 : cnt_q + SYM_PERIOD_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      copy_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      left_q   <= '0;
      symbol_q <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            symbol_q <= load_data[BITS_PER_SYM-1:0];
            shift_q  <= load_data >> BITS_PER_SYM;
            copy_q   <= load_data;
            period_q <= period;
            left_q   <= LAST_IDX;
            cnt_q    <= '0;
            strobe_q <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort outranks a coinciding symbol boundary, so no pulse escapes.
          if (abort) begin
            state_q  <= S_IDLE;
            symbol_q <= '0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (boundary) begin
              if (left_q != '0) begin
                symbol_q <= shift_q[BITS_PER_SYM-1:0];
                shift_q  <= shift_q >> BITS_PER_SYM;
                left_q   <= left_q - LEFT_W'(1);
                strobe_q <= 1'b1;
              end else if (loop_en) begin
                symbol_q <= copy_q[BITS_PER_SYM-1:0];
                shift_q  <= copy_q >> BITS_PER_SYM;
                left_q   <= LAST_IDX;
                strobe_q <= 1'b1;
                wrap_q   <= 1'b1;
              end else begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign sym_i      = symbol_q[HALF-1:0];
  assign sym_q      = symbol_q[BITS_PER_SYM-1:HALF];
  assign elojel_sin = symbol_q[HALF-1];
  assign elojel_cos = symbol_q[BITS_PER_SYM-1];
  assign sym_strobe = strobe_q;
  assign wrap       = wrap_q;
  assign done       = done_q;
  assign busy       = (state_q == S_RUN);
  assign load_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_qam_symbol_source.sv
// tb/tb_qam_symbol_source.sv - bench for qam_symbol_source
// Two instances: default geometry and a 4-bit-symbol, 8-bit-pattern variant.
module tb_qam_symbol_source;

  localparam int BPS  = 2;
  localparam int HALF = 1;
  localparam int NSYM = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_valid, load_ready, loop_en, abort;
  logic [29:0] load_data;
  logic [10:0] period;
  logic [0:0]  sym_i, sym_q;
  logic        elojel_sin, elojel_cos, sym_strobe, wrap, done, busy;

  logic        lv2, lr2, le2, ab2;
  logic [7:0]  ld2;
  logic [10:0] p2;
  logic [1:0]  si2, sq2;
  logic        es2, ec2, st2, wr2, dn2, bs2;

  logic [8:0]  obs1;
  logic [10:0] obs2;
  assign obs1 = {sym_i, sym_q, elojel_sin, elojel_cos, sym_strobe, wrap, done, busy, load_ready};
  assign obs2 = {si2, sq2, es2, ec2, st2, wr2, dn2, bs2, lr2};

  int vectors = 0;
  int miscompares = 0;

  qam_symbol_source dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .period(period), .loop_en(loop_en), .abort(abort),
    .sym_i(sym_i), .sym_q(sym_q), .elojel_sin(elojel_sin), .elojel_cos(elojel_cos),
    .sym_strobe(sym_strobe), .wrap(wrap), .done(done), .busy(busy)
  );

  qam_symbol_source #(.PATTERN_W(8), .BITS_PER_SYM(4), .SYM_PERIOD_W(11)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2),
    .load_data(ld2), .period(p2), .loop_en(le2), .abort(ab2),
    .sym_i(si2), .sym_q(sq2), .elojel_sin(es2), .elojel_cos(ec2),
    .sym_strobe(st2), .wrap(wr2), .done(dn2), .busy(bs2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Expected outputs t cycles after acceptance, derived from symbol index arithmetic.
  function automatic logic [8:0] expect1(input longint d, input int p, input bit lp, input int t);
    int per, len, k;
    longint s, i, q;
    bit strobe, wrp, dn, bsy;
    per = p + 1;
    len = NSYM * per;
    if (!lp && t >= len) begin
      k = NSYM - 1; strobe = 0; wrp = 0; dn = (t == len); bsy = 0;
    end else begin
      k = (t / per) % NSYM; strobe = (t % per == 0);
      wrp = lp && t > 0 && (t % len == 0); dn = 0; bsy = 1;
    end
    s = (d >> (BPS * k)) % (1 << BPS);
    i = s % (1 << HALF);
    q = s >> HALF;
    return {1'(i), 1'(q), 1'(i >> (HALF - 1)), 1'(q >> (HALF - 1)), strobe, wrp, dn, bsy, !bsy};
  endfunction

  function automatic logic [10:0] expect2(input int t);
    int s, i, q;
    bit strobe, dn, bsy;
    if (t >= 4) begin
      s = 'hA; strobe = 0; dn = (t == 4); bsy = 0;
    end else begin
      s = ('hA5 >> (4 * (t / 2))) % 16; strobe = (t % 2 == 0); dn = 0; bsy = 1;
    end
    i = s % 4;
    q = s / 4;
    return {2'(i), 2'(q), 1'(i / 2), 1'(q / 2), strobe, 1'b0, dn, bsy, !bsy};
  endfunction

  task automatic accept(input logic [29:0] d, input int p);
    load_valid = 1'b1;
    load_data  = d;
    period     = 11'(p);
    tick();
    load_valid = 1'b0;
    load_data  = 30'($urandom);
    period     = 11'($urandom);
  endtask

  task automatic follow(input logic [29:0] d, input int p, input bit lp,
                        input int t0, input int t1, input int abort_t);
    for (int t = t0; t <= t1; t++) begin
      if (t > t0) tick();
      check("play", 16'(obs1), 16'(expect1(d, p, lp, t)));
      if (t == abort_t) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort", 16'(obs1), 16'h0001);
        break;
      end
    end
  endtask

  initial begin
    logic [29:0] d, d2;
    int p, len;
    bit lp;

    rst = 1'b1; load_valid = 1'b1; load_data = 30'h3FFFFFE6; period = 11'd0;
    loop_en = 1'b0; abort = 1'b0;
    lv2 = 1'b1; ld2 = 8'hA5; p2 = 11'd0; le2 = 1'b0; ab2 = 1'b0;
    repeat (3) begin
      tick();
      check("reset", 16'(obs1), 16'h0001);
      check("reset2", 16'(obs2), 16'h0001);
    end
    rst = 1'b0; load_valid = 1'b0; lv2 = 1'b0;
    tick();
    check("idle", 16'(obs1), 16'h0001);

    d = 30'h3FFFFFE6;
    accept(d, 3);
    follow(d, 3, 0, 0, 62, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_idle", 16'(obs1), 16'(expect1(d, 3, 0, 63)));

    loop_en = 1'b1;
    accept(d, 0);
    follow(d, 0, 1, 0, 40, 40);

    d = 30'($urandom);
    accept(d, 0);
    follow(d, 0, 1, 0, 20, -1);
    loop_en = 1'b0;
    tick();
    follow(d, 0, 0, 6, 17, -1);

    d = 30'($urandom);
    d2 = 30'($urandom);
    accept(d, 2);
    follow(d, 2, 0, 0, 12, 12);
    accept(d2, 1);
    follow(d2, 1, 0, 0, 31, -1);

    d = 30'($urandom);
    d2 = 30'($urandom);
    load_valid = 1'b1; load_data = d; period = 11'd1;
    tick();
    load_data = d2; period = 11'd2;
    follow(d, 1, 0, 0, 30, -1);
    tick();
    load_valid = 1'b0;
    follow(d2, 2, 0, 0, 46, -1);

    repeat (6) begin
      d = 30'($urandom);
      p = $urandom_range(0, 4);
      lp = 1'($urandom_range(0, 1));
      len = NSYM * (p + 1);
      loop_en = lp;
      accept(d, p);
      if (lp) follow(d, p, 1, 0, 2 * len + len / 2, 2 * len + len / 2);
      else    follow(d, p, 0, 0, len + 1, -1);
      loop_en = 1'b0;
    end

    accept(30'($urandom), 3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid", 16'(obs1), 16'h0001);

    lv2 = 1'b1; ld2 = 8'hA5; p2 = 11'd1;
    tick();
    lv2 = 1'b0; ld2 = 8'h00; p2 = 11'd7;
    for (int t = 0; t <= 5; t++) begin
      if (t > 0) tick();
      check("bps4", 16'(obs2), 16'(expect2(t)));
    end
    lv2 = 1'b1; ld2 = 8'hA5; p2 = 11'd1;
    tick();
    lv2 = 1'b0;
    check("bps4_rerun", 16'(obs2), 16'(expect2(0)));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("bps4_rst_mid", 16'(obs2), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qam_symbol_source.md
# qam_symbol_source

Parametrised symbol stimulus source for the QAM modulator datapath. It accepts a packed bit pattern over a valid/ready load handshake and slices it LSB-first into symbols of BITS_PER_SYM bits. Each symbol drives the I (sine) and Q (cosine) level fields for a programmable number of clock cycles. Outputs feed the sine/cosine sign and level inputs of the modulator top level. The block supports one-shot and looping playback, abort, and per-symbol strobes.

## Interface
- PATTERN_W, 30, pattern width in bits; must be a multiple of BITS_PER_SYM
- BITS_PER_SYM, 2, bits per symbol; even, ≥2; HALF = BITS_PER_SYM/2
- SYM_PERIOD_W, 11, width of the symbol-period field
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  pattern offered
- load_ready  out  1  block can accept a pattern
- load_data  in  PATTERN_W  pattern; symbol 0 = bits [BITS_PER_SYM-1:0]
- period  in  SYM_PERIOD_W  cycles per symbol minus 1; sampled at load acceptance
- loop_en  in  1  replay pattern when exhausted; sampled at each pattern end
- abort  in  1  stop playback
- sym_i  out  HALF  I level = symbol bits [HALF-1:0]
- sym_q  out  HALF  Q level = symbol bits [BITS_PER_SYM-1:HALF]
- elojel_sin  out  1  sym_i[HALF-1]
- elojel_cos  out  1  sym_q[HALF-1]
- sym_strobe  out  1  one-cycle pulse: new symbol presented this cycle
- wrap  out  1  one-cycle pulse: loop restarted at symbol 0
- done  out  1  one-cycle pulse: one-shot playback finished
- busy  out  1  state == RUN

## Operation
- NSYM = PATTERN_W/BITS_PER_SYM. Registers: shift reg, pattern copy, period_reg, cycle counter (SYM_PERIOD_W), symbol-left counter.
- States: IDLE, RUN. load_ready = (state == IDLE).
- IDLE, load_valid: accept. Then:
  - sym ← load_data[BITS_PER_SYM-1:0], shift ← load_data >> BITS_PER_SYM, copy ← load_data.
  - period_reg ← period, left ← NSYM-1, cnt ← 0.
  - sym_strobe ← 1, state ← RUN.
- RUN: cnt increments each cycle. When cnt == period_reg, cnt ← 0 and:
  - left ≠ 0: next symbol from shift; shift >>= BITS_PER_SYM; left−1; sym_strobe.
  - left == 0 and loop_en: reload from copy; present symbol 0; sym_strobe and wrap pulse.
  - left == 0 and !loop_en: state ← IDLE; done pulse; sym_i/sym_q hold the last symbol.
- abort in RUN: state ← IDLE next edge; sym_i/sym_q ← 0; no strobe, wrap or done. abort in IDLE has no effect.
- Priority: rst > abort > symbol boundary. rst or abort in the same cycle as a boundary suppresses every pulse.

## Timing
- Reset (rst high at an edge):
  - state IDLE; all outputs 0 except load_ready = 1.
  - counters and registers cleared.
  - load_valid is ignored while rst is high.
- Latency:
  - Acceptance at edge E0: sym_i/sym_q/sym_strobe valid from E0.
  - Symbol k is presented from E0 + k·(period+1).
- Each symbol is held exactly period+1 cycles. Period 0 gives a new symbol every cycle, with sym_strobe continuously high.
- One-shot end:
  - done, busy = 0 and load_ready = 1 from E0 + NSYM·(period+1).
  - A new load is accepted at the next edge, or later.
- Loop: no gap between the last symbol and the wrapped symbol 0.
- Inputs period and load_data are ignored outside acceptance. loop_en is only sampled at pattern end.

## Test plan
- Reset: rst high 3 cycles, load_valid = 1 throughout → all outputs 0, load_ready = 1, nothing accepted.
- One-shot, PATTERN_W 30, BITS_PER_SYM 2, load_data 30'h3FFFFFE6, period 3:
  - sym (i,q) = (0,1), (1,0), (0,1), (1,1), … changing every 4 cycles.
  - 15 strobes; done at E0+60; sym holds (1,1).
- Loop, same pattern, period 0, loop_en 1:
  - strobe every cycle; sequence repeats every 15 cycles.
  - wrap at E0+15, E0+30; done never asserts.
- Abort after the 5th strobe → IDLE next edge, sym 0, load_ready 1, no done. Reload is accepted on the next cycle.
- load_valid held high during RUN → not accepted until the edge after done. Second playback starts at symbol 0 with the new period.
- BITS_PER_SYM 4, PATTERN_W 8, load 8'hA5, period 1:
  - sym_i = 2'b01, sym_q = 2'b01, elojel both 0.
  - then sym_i = 2'b10, sym_q = 2'b10, elojel both 1.
  - done at E0+4.
  - rst mid-symbol in a rerun → all outputs 0 next edge.
